// File: rtl/generic_adapt_pkg.sv
// Shared types and constants for the generic DFE adaptation loop.
package generic_adapt_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } adapt_state_e;

    localparam int DLEV_RESET = 8;
    localparam int CODE_MAX   = 15;
    localparam int NUM_CODES  = 5;
    localparam int HIST_W     = 4;

    typedef logic signed [5:0] vote_t;
endpackage

// File: rtl/generic_vote_counter.sv
// Sign-sign vote over one parallel word: compares each error bit against the data bit LAG
// positions earlier (LAG=0 compares against the data bit itself, i.e. the dlev vote).
module generic_vote_counter
    import generic_adapt_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LAG    = 0
) (
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] err,
    input  logic [HIST_W-1:0] hist,
    input  logic              hist_valid,
    output vote_t             vote
);
    // Previous word's top bits sit below the current word so d[i-k] is ext[i+HIST_W-k].
    logic [DATA_W+HIST_W-1:0] ext;
    assign ext = {data, hist};

    always_comb begin
        vote = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i] && (i >= LAG || hist_valid)) begin
                if (err[i] == ext[i+HIST_W-LAG]) vote = vote + 6'sd1;
                else                              vote = vote - 6'sd1;
            end
        end
    end
endmodule

// File: rtl/generic_dfe_adapter.sv
// Sign-sign LMS adaptation of the dlev DAC code and four DFE tap codes,
// with a three-stage vote pipeline and periodic code updates.
module generic_dfe_adapter
    import generic_adapt_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int CODE_W      = 4,
    parameter int ACC_W       = 12,
    parameter int PERIOD_LOG2 = 6,
    parameter int ACQ_UPDATES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [CODE_W-1:0]   dlev_init,
    input  logic [4*CODE_W-1:0] taps_init,
    input  logic [7:0]          threshold,
    input  logic [DATA_W-1:0]   data_rx,
    input  logic [DATA_W-1:0]   data_dlev,
    output logic [CODE_W-1:0]   dlev_dac,
    output logic [CODE_W-1:0]   dfe_taps_0,
    output logic [CODE_W-1:0]   dfe_taps_1,
    output logic [CODE_W-1:0]   dfe_taps_2,
    output logic [CODE_W-1:0]   dfe_taps_3,
    output logic [1:0]          state,
    output logic                locked,
    output logic                update_strobe
);
    localparam int SUM_W     = ACC_W + 1;
    localparam int ACQ_CNT_W = $clog2(ACQ_UPDATES + 1);
    localparam int ACC_LIM   = 2**(ACC_W-1) - 1;
    localparam logic signed [SUM_W-1:0] SUM_LIM = SUM_W'(ACC_LIM);
    localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(ACC_LIM);
    localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;

    adapt_state_e state_q, state_d;
    logic [DATA_W-1:0] rx1, err1;
    logic [HIST_W-1:0] hist1;
    logic v1, hv1, v2;
    vote_t vote_c [NUM_CODES];
    vote_t vote_q [NUM_CODES];
    logic signed [ACC_W-1:0] acc_q   [NUM_CODES];
    logic signed [ACC_W-1:0] acc_sat [NUM_CODES];
    logic signed [SUM_W-1:0] acc_sum [NUM_CODES];
    logic [CODE_W-1:0] code_q [NUM_CODES];
    logic [CODE_W-1:0] code_d [NUM_CODES];
    logic [PERIOD_LOG2-1:0] word_cnt;
    logic [ACQ_CNT_W-1:0] acq_cnt;
    logic signed [SUM_W-1:0] thr_s;
    logic active, close;

    assign active = enable && !load && (state_q != IDLE);
    assign close  = active && v2 && (word_cnt == '1);
    assign thr_s  = $signed({{(SUM_W-8){1'b0}}, threshold});

    for (genvar k = 0; k < NUM_CODES; k++) begin : g_vote
        generic_vote_counter #(.DATA_W(DATA_W), .LAG(k)) u_vote (
            .data(rx1), .err(err1), .hist(hist1), .hist_valid(hv1), .vote(vote_c[k])
        );
    end

    // Index 0 is dlev; taps only learn once the dlev loop has settled (TRACK).
    always_comb begin
        for (int k = 0; k < NUM_CODES; k++) begin
            acc_sum[k] = {acc_q[k][ACC_W-1], acc_q[k]};
            if (k == 0 || state_q == TRACK) acc_sum[k] = acc_sum[k] + SUM_W'(vote_q[k]);
            if (acc_sum[k] > SUM_LIM)       acc_sat[k] = ACC_POS;
            else if (acc_sum[k] < -SUM_LIM) acc_sat[k] = ACC_NEG;
            else                            acc_sat[k] = acc_sum[k][ACC_W-1:0];
            code_d[k] = code_q[k];
            if (acc_sum[k] > thr_s && code_q[k] != CODE_W'(CODE_MAX)) code_d[k] = code_q[k] + 1'b1;
            else if (acc_sum[k] < -thr_s && code_q[k] != '0)         code_d[k] = code_q[k] - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load || !enable) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    state_d = ACQUIRE;
                ACQUIRE: if (close && acq_cnt == ACQ_CNT_W'(ACQ_UPDATES-1)) state_d = TRACK;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Any inactive cycle (IDLE, load, enable low) discards everything in flight.
    always_ff @(posedge clock) begin
        if (!reset || !active) begin
            rx1 <= '0; err1 <= '0; hist1 <= '0;
            v1 <= 1'b0; hv1 <= 1'b0; v2 <= 1'b0;
            word_cnt <= '0; acq_cnt <= '0; update_strobe <= 1'b0;
            for (int k = 0; k < NUM_CODES; k++) begin
                vote_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            rx1   <= data_rx;
            err1  <= data_dlev;
            hist1 <= rx1[DATA_W-1 -: HIST_W];
            v1    <= 1'b1;
            hv1   <= v1;
            v2    <= v1;
            for (int k = 0; k < NUM_CODES; k++) vote_q[k] <= vote_c[k];
            update_strobe <= close;
            if (v2) begin
                word_cnt <= word_cnt + 1'b1;
                for (int k = 0; k < NUM_CODES; k++) acc_q[k] <= close ? '0 : acc_sat[k];
                if (close && state_q == ACQUIRE) acq_cnt <= acq_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            code_q[0] <= CODE_W'(DLEV_RESET);
            for (int k = 1; k < NUM_CODES; k++) code_q[k] <= '0;
        end else if (load) begin
            code_q[0] <= dlev_init;
            for (int k = 1; k < NUM_CODES; k++) code_q[k] <= taps_init[(k-1)*CODE_W +: CODE_W];
        end else if (close) begin
            for (int k = 0; k < NUM_CODES; k++) code_q[k] <= code_d[k];
        end
    end

    assign dlev_dac   = code_q[0];
    assign dfe_taps_0 = code_q[1];
    assign dfe_taps_1 = code_q[2];
    assign dfe_taps_2 = code_q[3];
    assign dfe_taps_3 = code_q[4];
    assign state      = state_q;
    assign locked     = (state_q == TRACK);
endmodule
